// File: rtl/repeating_key_cipher_stream_if.sv
// repeating_key_cipher_stream_if: valid/ready symbol stream with end-of-message marker
interface repeating_key_cipher_stream_if #(parameter int DATA_W = 8);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/repeating_key_cipher_stream.sv
// repeating_key_cipher_stream: streaming add/sub/xor cipher against a programmable repeating key
module repeating_key_cipher_stream #(
  parameter int DATA_W    = 8,
  parameter int KEY_MAX   = 16,
  parameter int KEY_IDX_W = $clog2(KEY_MAX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_wr_en,
  input  logic [KEY_IDX_W-1:0] key_wr_idx,
  input  logic [DATA_W-1:0]    key_wr_data,
  input  logic [KEY_IDX_W:0]   key_len,
  input  logic [1:0]           mode,
  input  logic                 start,
  repeating_key_cipher_stream_if.slave  s_in,
  repeating_key_cipher_stream_if.master m_out,
  output logic                 busy,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t               r_state;
  logic [DATA_W-1:0]    r_key [KEY_MAX];
  logic [KEY_IDX_W-1:0] r_idx;
  logic [KEY_IDX_W:0]   r_len;
  logic [1:0]           r_mode;
  logic [DATA_W-1:0]    r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_err;
  logic                 w_cfg_ok;
  logic                 w_in_hs;
  logic                 w_out_hs;
  logic [KEY_IDX_W-1:0] w_idx_max;
  logic [DATA_W-1:0]    w_key;
  logic [DATA_W-1:0]    w_res;
  assign w_cfg_ok  = key_len != '0 && key_len <= (KEY_IDX_W+1)'(KEY_MAX) && mode != 2'b11;
  assign w_in_hs   = s_in.valid && s_in.ready;
  assign w_out_hs  = r_out_valid && m_out.ready;
  assign w_idx_max = KEY_IDX_W'(r_len - 1'b1);
  assign w_key     = r_key[r_idx];
  assign s_in.ready  = r_state == RUN && (!r_out_valid || m_out.ready);
  assign m_out.valid = r_out_valid;
  assign m_out.data  = r_out_data;
  assign m_out.last  = r_out_last;
  assign busy        = r_state != IDLE;
  assign err         = r_err;
  always_comb begin
    w_res = r_mode == 2'b00 ? s_in.data + w_key :
            r_mode == 2'b01 ? s_in.data - w_key : s_in.data ^ w_key;
  end
  // Key is frozen for the whole message, so writes only land while idle
  always_ff @(posedge clk) begin
    if (key_wr_en && r_state == IDLE) r_key[key_wr_idx] <= key_wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_mode      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_out_data  <= w_res;
        r_out_valid <= 1'b1;
        r_out_last  <= s_in.last;
        r_idx       <= (s_in.last || r_idx == w_idx_max) ? '0 : r_idx + 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      case (r_state)
        IDLE: if (start) begin
          if (w_cfg_ok) begin
            r_len   <= key_len;
            r_mode  <= mode;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_state <= RUN;
          end else r_err <= 1'b1;
        end
        RUN:   if (w_in_hs && s_in.last) r_state <= FLUSH;
        FLUSH: if (w_out_hs && r_out_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_repeating_key_cipher_stream.sv
// tb_repeating_key_cipher_stream: directed and random checks against a queue-based cipher model
module tb_repeating_key_cipher_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_wr_en = 1'b0;
  logic [3:0] key_wr_idx = '0;
  logic [7:0] key_wr_data = '0;
  logic [4:0] key_len = '0;
  logic [1:0] mode = '0;
  logic       start = 1'b0;
  logic       busy, err;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] mk [16];
  logic [7:0] din [$];
  logic [7:0] got [$];
  repeating_key_cipher_stream_if #(.DATA_W(8)) in_if();
  repeating_key_cipher_stream_if #(.DATA_W(8)) out_if();
  repeating_key_cipher_stream dut (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .key_len(key_len), .mode(mode), .start(start),
    .s_in(in_if), .m_out(out_if), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic write_key(input int idx, input int val);
    @(negedge clk);
    key_wr_en = 1'b1; key_wr_idx = 4'(idx); key_wr_data = 8'(val);
    @(negedge clk);
    key_wr_en = 1'b0;
  endtask
  task automatic do_start(input int len, input int md, input logic exp_busy, input logic exp_err);
    @(negedge clk);
    start = 1'b1; key_len = 5'(len); mode = 2'(md);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_busy", busy, exp_busy);
    chk("start_err", err, exp_err);
  endtask
  // bp: 0 = sink always ready, 1 = random stalls both sides, 2 = out_ready pattern 1,0,0,1
  task automatic run_msg(input int md, input int len, input int bp);
    logic [7:0] exp_q [$];
    logic [3:0] pat = 4'b1001;
    int n = din.size();
    int sent = 0;
    int cyc = 0;
    logic mv = 1'b0;
    logic exp_rdy;
    logic out_hs;
    got.delete();
    for (int i = 0; i < n; i++) begin
      int k = int'(mk[i % len]);
      int d = int'(din[i]);
      exp_q.push_back(md == 0 ? 8'((d + k) % 256) : md == 1 ? 8'((d - k + 256) % 256) : 8'(d ^ k));
    end
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      out_if.ready = bp == 0 ? 1'b1 : bp == 2 ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      in_if.valid  = sent < n && (bp != 1 || $urandom_range(0, 3) != 0);
      in_if.data   = sent < n ? din[sent] : 8'h00;
      in_if.last   = sent == n - 1;
      #1;
      chk("out_valid", out_if.valid, mv);
      exp_rdy = sent < n && (!mv || out_if.ready);
      chk("in_ready", in_if.ready, exp_rdy);
      out_hs = mv && out_if.ready;
      if (mv) begin
        chk("out_data", out_if.data, exp_q[0]);
        chk("out_last", out_if.last, exp_q.size() == 1);
      end
      if (out_hs) begin
        got.push_back(out_if.data);
        void'(exp_q.pop_front());
      end
      if (exp_rdy && in_if.valid) begin
        sent++;
        mv = 1'b1;
      end else if (out_hs) mv = 1'b0;
      cyc++;
    end
    in_if.valid = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    #1;
    chk("busy_end", busy, 0);
    chk("valid_end", out_if.valid, 0);
  endtask
  task automatic cmp_got(input string tag, input logic [7:0] r [], input int n);
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) chk(tag, i < got.size() ? got[i] : 8'hxx, r[i]);
  endtask
  initial begin
    logic [7:0] r_add [] = '{140, 134, 154, 140};
    logic [7:0] r_a65 [] = '{65, 65, 65, 65};
    logic [7:0] r_xor [] = '{10, 4, 24};
    logic [7:0] r_rst [] = '{140, 134, 154, 140, 134};
    in_if.valid = 1'b0; in_if.data = '0; in_if.last = 1'b0; out_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_if.ready, 0);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_last", out_if.last, 0);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    mk[0] = 75; mk[1] = 69; mk[2] = 89;
    for (int i = 0; i < 3; i++) write_key(i, mk[i]);
    din = '{65, 65, 65, 65};
    do_start(3, 0, 1, 0);
    run_msg(0, 3, 0);
    cmp_got("add", r_add, 4);
    din = '{140, 134, 154, 140};
    do_start(3, 1, 1, 0);
    run_msg(1, 3, 0);
    cmp_got("sub", r_a65, 4);
    din = '{65, 65, 65};
    do_start(3, 2, 1, 0);
    run_msg(2, 3, 0);
    cmp_got("xor", r_xor, 3);
    din = got;
    do_start(3, 2, 1, 0);
    run_msg(2, 3, 0);
    cmp_got("xor_back", r_a65, 3);
    din = '{65, 65, 65, 65};
    do_start(3, 0, 1, 0);
    run_msg(0, 3, 2);
    cmp_got("backpressure", r_add, 4);
    do_start(0, 0, 0, 1);
    do_start(3, 3, 0, 1);
    do_start(17, 0, 0, 1);
    do_start(3, 0, 1, 0);
    do_start(0, 0, 1, 0);
    write_key(0, 0);
    din = '{65, 65, 65};
    run_msg(0, 3, 0);
    cmp_got("key_locked", r_add, 3);
    do_start(3, 0, 1, 0);
    write_key(1, 0);
    out_if.ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      in_if.valid = 1'b1; in_if.data = 8'd65; in_if.last = 1'b0;
    end
    @(negedge clk);
    in_if.valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_if.valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_if.ready, 0);
    rst = 1'b0;
    din = '{65, 65, 65, 65, 65};
    do_start(3, 0, 1, 0);
    run_msg(0, 3, 0);
    cmp_got("after_rst", r_rst, 5);
    for (int it = 0; it < 8; it++) begin
      int len = it == 0 ? 1 : it == 1 ? 16 : int'($urandom_range(1, 16));
      int md = int'($urandom_range(0, 2));
      int n = int'($urandom_range(1, 20));
      for (int j = 0; j < 16; j++) begin
        mk[j] = 8'($urandom);
        write_key(j, mk[j]);
      end
      din.delete();
      for (int j = 0; j < n; j++) din.push_back(8'($urandom));
      do_start(len, md, 1, 0);
      run_msg(md, len, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/repeating_key_cipher_stream.md
Name: repeating_key_cipher_stream

Overview:
- Streaming repeating-key cipher engine; successor to the fixed-length combinational decryptor.
- Encrypts or decrypts a byte stream of arbitrary length against a programmable key of 1..KEY_MAX symbols.
- Supports additive, subtractive and XOR modes.
- Sits between a message source and sink on valid/ready handshakes; the key is loaded through a register-style write port.

Parameters:
DATA_W, 8, symbol width in bits; all arithmetic is modulo 2^DATA_W
KEY_MAX, 16, maximum key length in symbols (key RAM depth)
KEY_IDX_W, $clog2(KEY_MAX), width of key index and length fields

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_wr_en  in  1  write key_wr_data into key[key_wr_idx]
key_wr_idx  in  KEY_IDX_W  key slot address
key_wr_data  in  DATA_W  key symbol
key_len  in  KEY_IDX_W+1  active key length, sampled on start
mode  in  2  sampled on start: 00 add (enc), 01 sub (dec), 10 xor, 11 reserved
start  in  1  one-cycle pulse that opens a message
in_valid  in  1  input symbol valid
in_ready  out  1  input can be accepted
in_data  in  DATA_W  input symbol
in_last  in  1  marks final symbol of message
out_valid  out  1  output symbol valid
out_ready  in  1  sink accepts output
out_data  out  DATA_W  transformed symbol
out_last  out  1  final symbol of message
busy  out  1  message in progress
err  out  1  sticky config error, cleared by the next accepted start

Behaviour:
- Reset: FSM=IDLE, key index=0. in_ready, out_valid, out_last, busy and err are all 0. out_data=0. Key RAM contents are unchanged.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, start=1:
  - key_len in 1..KEY_MAX and mode!=11: latch len/mode, idx=0, err=0, go to RUN.
  - Otherwise: err=1, stay IDLE.
- IDLE: start=0 holds IDLE. in_ready=0 in IDLE and FLUSH.
- RUN:
  - in_ready = !out_valid || out_ready (single output register, no bubble at full throughput).
  - Input handshake (in_valid && in_ready) loads out_data next cycle:
    - add: in_data + key[idx]
    - sub: in_data - key[idx]
    - xor: in_data ^ key[idx]
  - Truncate the result to DATA_W. out_valid=1 and out_last=in_last.
  - Latency: exactly 1 cycle from input handshake to out_valid.
  - idx advances on each input handshake and wraps to 0 after len-1; len=1 keeps idx=0.
  - Input handshake with in_last=1: go to FLUSH, idx=0.
- FLUSH: wait until the last output handshake (out_valid && out_ready && out_last), then go to IDLE with busy=0 in the same cycle.
- Output hold: while out_valid && !out_ready, out_data and out_last are held stable.
- busy=1 in RUN and FLUSH.
- start while busy: ignored, no error.
- key_wr_en while busy: ignored, so the key stays stable mid-message. In IDLE the write takes effect next cycle, and a start in that same cycle uses the new value.
- Simultaneous output drain and new input in RUN: both handshakes complete and the register is reloaded, so out_valid stays 1.
- rst mid-message: all state clears on the next edge and the partial message is discarded.
- mode 11 or key_len=0 or key_len>KEY_MAX: rejected at start with err=1.

Test Plan:
- Key 75,69,89 ("KEY"), len=3, add, input 65 x4, in_last on 4th, out_ready=1 -> outputs 140,134,154,140; out_last on 4th; busy falls after 4th output handshake.
- Same key, sub, input 140,134,154,140 -> 65,65,65,65. Key index restarts at 0 for a second message without rewriting the key.
- xor, key "KEY", input 65,65,65 -> 10,4,24. Re-run xor on the outputs -> 65,65,65.
- Backpressure: out_ready toggles 1,0,0,1 during the add stream -> in_ready=0 while output is held, data stable, no symbol lost or duplicated, order preserved.
- start with key_len=0, then mode=11 -> err=1, busy stays 0. Then a valid start -> err=0, busy=1.
- rst asserted after 2 of 5 symbols -> next cycle out_valid=0, busy=0. A new start and message begins at key index 0. A key_wr_en during RUN leaves the key unchanged.
